pwd_candidate_gen: RTL and testbench
====================================

PWD_CANDIDATE_GEN -- requirements
Module: pwd_candidate_gen

Interface
REQ-001 SHALL have parameter DIGITS, default 9, giving the number of ASCII decimal digits per candidate.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse that latches the range and begins generation.
REQ-005 SHALL have port abort  input  1  stops generation and returns to idle.
REQ-006 SHALL have port range_lo  input  8*DIGITS  first candidate, ASCII digits, most significant digit in the top byte.
REQ-007 SHALL have port range_hi  input  8*DIGITS  last candidate (inclusive), same format as range_lo.
REQ-008 SHALL have port cand_valid  output  1  cand_data holds a candidate.
REQ-009 SHALL have port cand_ready  input  1  the consumer accepts cand_data.
REQ-010 SHALL have port cand_data  output  8*DIGITS  current candidate, ASCII decimal.
REQ-011 SHALL have port cand_last  output  1  cand_data equals the latched range_hi.
REQ-012 SHALL have port busy  output  1  high in CHECK or ISSUE.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port err  output  1  the latched range was invalid.
REQ-015 SHALL have port issued_cnt  output  32  number of accepted candidates.

Function
REQ-016 SHALL implement the FSM states IDLE, CHECK, ISSUE and DONE.
REQ-017 SHALL, on start in IDLE or DONE, latch range_lo and range_hi, clear issued_cnt and err, and move to CHECK; start SHALL be ignored in CHECK and ISSUE.
REQ-018 SHALL, in CHECK (one cycle), set err and go to DONE if any byte of either bound lies outside "0".."9" or if lo > hi; otherwise it SHALL load cand_data with lo and go to ISSUE.
REQ-019 SHALL compare lo and hi as equal-length strings, byte by byte from the most significant byte; this comparison equals numeric order.
REQ-020 SHALL assert the first cand_valid exactly 2 cycles after the start pulse.
REQ-021 SHALL hold cand_valid at 1 throughout ISSUE; a handshake occurs when cand_valid and cand_ready are both 1 in the same cycle.
REQ-022 SHALL keep cand_data and cand_last stable while cand_valid=1 and cand_ready=0.
REQ-023 SHALL, on a handshake with cand_last=0, increment cand_data by one in ASCII decimal ("9" becomes "0" with a carry into the next byte up) in the next cycle, so back-to-back handshakes give one candidate per cycle.
REQ-024 SHALL, on a handshake with cand_last=1, go to DONE and deassert cand_valid the next cycle; the all-"9" wrap never occurs because hi bounds the count.
REQ-025 SHALL increment issued_cnt once per handshake and saturate it at 32'hFFFFFFFF.
REQ-026 SHALL hold done, err and issued_cnt in DONE until the next start, abort or reset.
REQ-027 SHALL, on abort in any state, enter IDLE on the next edge with cand_valid=0, busy=0 and done=0, keeping issued_cnt; abort SHALL win over a same-cycle start or handshake.
REQ-028 SHALL allow lo == hi; that case yields exactly one beat, with cand_last=1.

Reset
REQ-029 SHALL, on reset asserted, immediately set state=IDLE, cand_valid=0, cand_last=0, busy=0, done=0, err=0, issued_cnt=0, and cand_data to DIGITS ASCII "0" bytes.
REQ-030 SHALL, when reset is asserted mid-ISSUE, discard the in-flight candidate without completing its handshake.

Structure
REQ-031 SHALL place the DIGITS default, the ASCII_0/ASCII_9 constants and the FSM state encoding in shared package pwd_pkg.
REQ-032 SHALL implement the carry-chain incrementer as combinational sub-module ascii_dec_inc, with ports digits in, digits out and carry_out.

Verification
REQ-033 SHALL cover: lo="000000000", hi="000000003", cand_ready=1 -> beats 000000000..000000003 on consecutive cycles, cand_last on the 4th beat, then done=1 and issued_cnt=4.
REQ-034 SHALL cover: lo="000000998", hi="000001001" -> beats 000000998, 000000999, 000001000, 000001001 (multi-digit carry).
REQ-035 SHALL cover: cand_ready=0 for 5 cycles while cand_valid=1 -> cand_data unchanged and issued_cnt unchanged, then advance by one on the next handshake.
REQ-036 SHALL cover: lo="00000000A" or lo="000000005" with hi="000000004" -> err=1 and done=1 after 2 cycles, cand_valid never 1.
REQ-037 SHALL cover: abort after 3 beats -> cand_valid=0 next cycle, state IDLE, issued_cnt=3.
REQ-038 SHALL cover: start asserted while busy -> no effect.
REQ-039 SHALL cover: reset pulsed mid-ISSUE -> all outputs match REQ-029 immediately, before the next clock edge.

Source files
------------

// File: rtl/pwd_pkg.sv
// Shared constants and FSM encoding for the password candidate generator.
package pwd_pkg;

  localparam int unsigned PWD_DIGITS = 9;
  localparam logic [7:0]  ASCII_0    = 8'h30;
  localparam logic [7:0]  ASCII_9    = 8'h39;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } pwd_state_e;

endpackage

// File: rtl/ascii_dec_inc.sv
// Combinational ASCII decimal incrementer: adds one to a string of digits, '9' wraps to '0' with carry.
module ascii_dec_inc
  import pwd_pkg::*;
#(
  parameter int unsigned DIGITS = PWD_DIGITS
) (
  input  logic [8*DIGITS-1:0] digits_in,
  output logic [8*DIGITS-1:0] digits_out,
  output logic                carry_out
);

  logic carry;

  always_comb begin
    digits_out = digits_in;
    carry      = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (digits_in[8*i +: 8] == ASCII_9) begin
          digits_out[8*i +: 8] = ASCII_0;
        end else begin
          digits_out[8*i +: 8] = digits_in[8*i +: 8] + 8'd1;
          carry                = 1'b0;
        end
      end
    end
    carry_out = carry;
  end

endmodule

// File: rtl/pwd_candidate_gen.sv
// Streams every ASCII decimal candidate from a latched lo..hi range over a valid/ready interface.
module pwd_candidate_gen
  import pwd_pkg::*;
#(
  parameter int unsigned DIGITS = PWD_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [8*DIGITS-1:0] range_lo,
  input  logic [8*DIGITS-1:0] range_hi,
  output logic                cand_valid,
  input  logic                cand_ready,
  output logic [8*DIGITS-1:0] cand_data,
  output logic                cand_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         issued_cnt
);

  pwd_state_e          state_q, state_d;
  logic [8*DIGITS-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [8*DIGITS-1:0] cand_data_q, cand_data_d;
  logic                cand_valid_q, cand_valid_d;
  logic                cand_last_q, cand_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [31:0]         cnt_q, cnt_d;

  logic [8*DIGITS-1:0] inc_data;
  logic                inc_carry;
  logic                bounds_ok;
  logic                handshake;

  ascii_dec_inc #(
    .DIGITS (DIGITS)
  ) u_inc (
    .digits_in  (cand_data_q),
    .digits_out (inc_data),
    .carry_out  (inc_carry)
  );

  always_comb begin
    bounds_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (lo_q[8*i +: 8] < ASCII_0 || lo_q[8*i +: 8] > ASCII_9 ||
          hi_q[8*i +: 8] < ASCII_0 || hi_q[8*i +: 8] > ASCII_9) begin
        bounds_ok = 1'b0;
      end
    end
  end

  assign handshake = cand_valid_q && cand_ready;

  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    cand_data_d  = cand_data_q;
    cand_valid_d = cand_valid_q;
    cand_last_d  = cand_last_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    if (abort) begin
      state_d      = IDLE;
      cand_valid_d = 1'b0;
      cand_last_d  = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            lo_d    = range_lo;
            hi_d    = range_hi;
            cnt_d   = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          // Equal-length digit strings: whole-vector unsigned compare matches MSB-first byte compare.
          if (!bounds_ok || lo_q > hi_q) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            cand_data_d  = lo_q;
            cand_valid_d = 1'b1;
            cand_last_d  = (lo_q == hi_q);
            state_d      = ISSUE;
          end
        end
        ISSUE: begin
          if (handshake) begin
            if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
            // A carry out of the top digit would mean wrapping past all-9s; treat it as the end.
            if (cand_last_q || inc_carry) begin
              cand_valid_d = 1'b0;
              cand_last_d  = 1'b0;
              busy_d       = 1'b0;
              done_d       = 1'b1;
              state_d      = DONE;
            end else begin
              cand_data_d = inc_data;
              cand_last_d = (inc_data == hi_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lo_q         <= {DIGITS{ASCII_0}};
      hi_q         <= {DIGITS{ASCII_0}};
      cand_data_q  <= {DIGITS{ASCII_0}};
      cand_valid_q <= 1'b0;
      cand_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      cand_data_q  <= cand_data_d;
      cand_valid_q <= cand_valid_d;
      cand_last_q  <= cand_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cand_valid = cand_valid_q;
  assign cand_data  = cand_data_q;
  assign cand_last  = cand_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_pwd_candidate_gen.sv
// Directed bench for pwd_candidate_gen with hand-computed ASCII beat sequences.
module tb_pwd_candidate_gen;

  localparam int unsigned DIGITS = 9;
  localparam int unsigned W      = 8 * DIGITS;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic [W-1:0] range_lo;
  logic [W-1:0] range_hi;
  logic         cand_valid;
  logic         cand_ready;
  logic [W-1:0] cand_data;
  logic         cand_last;
  logic         busy;
  logic         done;
  logic         err;
  logic [31:0]  issued_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pwd_candidate_gen #(
    .DIGITS (DIGITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .range_lo   (range_lo),
    .range_hi   (range_hi),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_data  (cand_data),
    .cand_last  (cand_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one sampled edge; leaves the bench one edge later (DUT in CHECK).
  task automatic kick(input logic [W-1:0] lo, input logic [W-1:0] hi);
    range_lo = lo;
    range_hi = hi;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  logic [W-1:0] beats1 [4] = '{"000000000", "000000001", "000000002", "000000003"};
  logic [W-1:0] beats2 [4] = '{"000000998", "000000999", "000001000", "000001001"};
  logic [W-1:0] beats3 [3] = '{"000000101", "000000102", "000000103"};

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cand_ready = 1'b0;
    range_lo   = "000000000";
    range_hi   = "000000000";
    tick();
    tick();
    check("rst_valid", W'(cand_valid), W'(1'b0));
    check("rst_data",  cand_data, "000000000");
    check("rst_cnt",   W'(issued_cnt), W'(0));
    check("rst_flags", W'({busy, done, err, cand_last}), W'(4'b0000));
    reset = 1'b0;
    tick();

    // Basic run with consumer always ready.
    cand_ready = 1'b1;
    kick("000000000", "000000003");
    check("t1_check_valid", W'(cand_valid), W'(1'b0));
    check("t1_check_busy",  W'(busy), W'(1'b1));
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", W'(cand_valid), W'(1'b1));
      check("t1_data",  cand_data, beats1[i]);
      check("t1_last",  W'(cand_last), W'(i == 3));
      tick();
    end
    check("t1_end_valid", W'(cand_valid), W'(1'b0));
    check("t1_done",      W'({done, busy, err}), W'(3'b100));
    check("t1_cnt",       W'(issued_cnt), W'(4));
    tick();
    check("t1_hold_cnt",  W'(issued_cnt), W'(4));
    check("t1_hold_done", W'(done), W'(1'b1));

    // Multi-digit carry.
    kick("000000998", "000001001");
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_data", cand_data, beats2[i]);
      check("t2_last", W'(cand_last), W'(i == 3));
      tick();
    end
    check("t2_cnt",  W'(issued_cnt), W'(4));
    check("t2_done", W'(done), W'(1'b1));

    // Invalid digit in lo.
    kick("00000000A", "000000009");
    check("t3a_mid_valid", W'(cand_valid), W'(1'b0));
    tick();
    check("t3a_flags", W'({err, done, busy, cand_valid}), W'(4'b1100));
    // lo > hi.
    kick("000000005", "000000004");
    check("t3b_mid_valid", W'(cand_valid), W'(1'b0));
    tick();
    check("t3b_flags", W'({err, done, busy, cand_valid}), W'(4'b1100));
    tick();
    check("t3b_hold_valid", W'(cand_valid), W'(1'b0));

    // lo == hi: a single last beat, and err cleared by the new start.
    kick("000000042", "000000042");
    check("t4_err_clr", W'(err), W'(1'b0));
    tick();
    check("t4_data",  cand_data, "000000042");
    check("t4_vlast", W'({cand_valid, cand_last}), W'(2'b11));
    tick();
    check("t4_end", W'({cand_valid, done, err}), W'(3'b010));
    check("t4_cnt", W'(issued_cnt), W'(1));

    // Backpressure, then start while busy, then abort.
    cand_ready = 1'b0;
    kick("000000010", "000000020");
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_data", cand_data, "000000010");
      check("t5_stall_cnt",  W'(issued_cnt), W'(0));
      check("t5_stall_valid", W'(cand_valid), W'(1'b1));
      tick();
    end
    cand_ready = 1'b1;
    tick();
    cand_ready = 1'b0;
    check("t5_adv_data", cand_data, "000000011");
    check("t5_adv_cnt",  W'(issued_cnt), W'(1));
    kick("000000900", "000000950");
    check("t6_busy_data", cand_data, "000000011");
    tick();
    check("t6_busy_data2", cand_data, "000000011");
    check("t6_busy_state", W'({cand_valid, busy, done}), W'(3'b110));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort", W'({cand_valid, busy, done}), W'(3'b000));

    // Abort after three accepted beats, racing a handshake.
    cand_ready = 1'b1;
    kick("000000100", "000000200");
    tick();
    check("t7_first", cand_data, "000000100");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t7_data", cand_data, beats3[i]);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("t7_abort_flags", W'({cand_valid, busy, done}), W'(3'b000));
    check("t7_abort_cnt",   W'(issued_cnt), W'(3));
    tick();
    check("t7_idle_valid", W'(cand_valid), W'(1'b0));

    // Reset in the middle of ISSUE; outputs must clear before the next edge.
    kick("000000500", "000000600");
    tick();
    tick();
    check("t8_pre_data", cand_data, "000000501");
    #2;
    reset = 1'b1;
    #1;
    check("t8_rst_valid", W'(cand_valid), W'(1'b0));
    check("t8_rst_data",  cand_data, "000000000");
    check("t8_rst_flags", W'({busy, done, err, cand_last}), W'(4'b0000));
    check("t8_rst_cnt",   W'(issued_cnt), W'(0));
    tick();
    reset = 1'b0;
    tick();
    check("t8_post_valid", W'(cand_valid), W'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
